mode4_norm_dispatch: RTL and testbench
======================================

MODE4_NORM_DISPATCH -- requirements
Module: mode4_norm_dispatch

Interface
REQ-001 Parameter DATAWIDTH, default 16: width of every fp element, IEEE half precision.
REQ-002 Parameter LENWIDTH, default 8: width of the beat-count input.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a row.
REQ-006 len  input  LENWIDTH  number of 4-element beats in the row; sampled with start.
REQ-007 norm_in  input  DATAWIDTH  scalar reduction result, e.g. log-sum of the row; sampled with start.
REQ-008 in_valid / in_ready  input / output  1 each  upstream beat handshake.
REQ-009 inp0..inp3  input  DATAWIDTH each  four elements of the current input beat.
REQ-010 out_valid / out_ready  output / input  1 each  downstream beat handshake.
REQ-011 outp0..outp3  output  DATAWIDTH each  normalized elements.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse when the row completes.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN.
REQ-015 IDLE plus start with len>0: latch norm_in into norm_reg and len into beats_left, then go to RUN.
REQ-016 IDLE plus start with len==0: pulse done in the next cycle and stay in IDLE.
REQ-017 start while busy is ignored, and norm_reg and beats_left remain unchanged.
REQ-018 in_ready = (state==RUN) && (!out_valid || out_ready), i.e. a one-entry output register with pass-through on pop.
REQ-019 A beat is accepted when in_valid && in_ready.
REQ-020 On accept, outp_k registers inp_k - norm_reg for k=0..3, using DW_fp_sub with rnd=3'b000 (round to nearest even); out_valid is set the next cycle.
REQ-021 Latency from input accept to out_valid is exactly 1 cycle.
REQ-022 Full throughput of 1 beat per cycle is sustained while out_ready is held high.
REQ-023 out_valid && !out_ready holds outp0..3 and out_valid stable, and in_ready is low.
REQ-024 Simultaneous pop and accept in one cycle: out_valid stays high and the new data replaces the old data.
REQ-025 Each accept decrements beats_left by 1; the accept at beats_left==1 moves the FSM to DRAIN.
REQ-026 DRAIN: in_ready is low; when the final output is popped (out_valid && out_ready), pulse done in that same edge's next cycle and return to IDLE.
REQ-027 Inputs offered while in_ready is low are ignored and are not counted.
REQ-028 Special values (NaN, Inf, subnormals) follow DW_fp_sub behaviour, with no extra handling.

Reset
REQ-029 reset_n low asynchronously forces state=IDLE, out_valid=0, done=0, beats_left=0, norm_reg=0 and outp0..3=0.
REQ-030 in_ready and busy shall read 0 during reset.
REQ-031 Reset mid-row discards all in-flight data, and no done pulse is produced for the aborted row.

Structure
REQ-032 A shared package shall hold DATAWIDTH, LENWIDTH, the FSM state encoding and the rounding-mode constant 3'b000.
REQ-033 One sub-module, mode4_sub_row, shall be instantiated once and contain four combinational DW_fp_sub lanes sharing operand b.
REQ-034 The top module shall contain only the FSM, the counter, the handshake logic and the output register.

Verification
REQ-035 Basic row: start with norm_in=0x3C00 and len=1, beat in = 0x3C00, 0x4000, 0x4200, 0x4400, out_ready=1 -> out = 0x0000, 0x3C00, 0x4000, 0x4200 one cycle after accept, followed by a done pulse.
REQ-036 Streaming: len=4, in_valid and out_ready held high -> 4 consecutive out_valid cycles, no bubbles, and exactly one done.
REQ-037 Backpressure: out_ready=0 for 3 cycles mid-row -> outputs held stable, in_ready=0, no beat lost or duplicated, done after the 4th pop.
REQ-038 Zero length: start with len=0 -> done the next cycle, busy never high, out_valid never high.
REQ-039 Start while busy: a second start with norm_in=0x4000 during RUN -> outputs still use 0x3C00, and the beat count is unchanged.
REQ-040 Reset mid-row: assert reset_n=0 after 2 of 4 beats -> all outputs 0 immediately, no done; a new row after release completes correctly.

Source files
------------

// File: rtl/mode4_norm_dispatch_pkg.sv
// ============================================================================
// Module : mode4_norm_dispatch_pkg
// Brief  : Shared widths, FSM encoding, rounding mode and fp16 subtract helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mode4_norm_dispatch_pkg;

    localparam int c_DATAWIDTH = 16;
    localparam int c_LENWIDTH  = 8;

    localparam logic [2:0] c_RND_RNE = 3'b000;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_RUN   = 2'd1;
    localparam state_t c_ST_DRAIN = 2'd2;

    // IEEE half-precision a - b, round-to-nearest-even (rounding mode c_RND_RNE),
    // full subnormal support, canonical quiet NaN 0x7E00 on invalid operations.
    function automatic logic [15:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bn, big, sml, res;
        logic        a_nan, b_nan, a_inf, b_inf;
        logic [5:0]  e_big, e_sml, d, ee, lim, shift;
        logic [10:0] m_big, m_sml, mf;
        logic [47:0] sh;
        logic [13:0] al, as_, nrm;
        logic [14:0] sum;
        logic [3:0]  lz;
        logic        found, rup;
        logic [11:0] m12;
        bn    = {~b[15], b[14:0]};
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);
        big   = (bn[14:0] > a[14:0]) ? bn : a;
        sml   = (bn[14:0] > a[14:0]) ? a  : bn;
        e_big = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
        e_sml = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
        m_big = {|big[14:10], big[9:0]};
        m_sml = {|sml[14:10], sml[9:0]};
        d     = e_big - e_sml;
        sh    = {m_sml, 37'd0} >> d;
        al    = {m_big, 3'b000};
        as_   = {sh[47:35], sh[34] | (|sh[33:0])};
        if (big[15] == sml[15]) begin
            sum = {1'b0, al} + {1'b0, as_};
        end else begin
            sum = {1'b0, al - as_};
        end
        ee    = e_big;
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 4'(13 - i);
            end
        end
        // Left shifts stop at exponent 1 so that tiny results come out subnormal.
        lim   = ee - 6'd1;
        shift = ({2'b00, lz} > lim) ? lim : {2'b00, lz};
        if (sum[14]) begin
            nrm = {sum[14:2], sum[1] | sum[0]};
            ee  = ee + 6'd1;
        end else begin
            nrm = sum[13:0] << shift;
            ee  = ee - shift;
        end
        rup = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        m12 = {1'b0, nrm[13:3]} + {11'd0, rup};
        if (m12[11]) begin
            mf = m12[11:1];
            ee = ee + 6'd1;
        end else begin
            mf = m12[10:0];
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != bn[15]))) begin
            res = 16'h7E00;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = {bn[15], 15'h7C00};
        end else if (sum == 15'd0) begin
            res = {big[15] & sml[15], 15'd0};
        end else if (ee >= 6'd31) begin
            res = {big[15], 15'h7C00};
        end else begin
            res = {big[15], (mf[10] ? ee[4:0] : 5'd0), mf[9:0]};
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mode4_norm_dispatch_sub_row.sv
// ============================================================================
// Module : mode4_sub_row
// Brief  : Four combinational fp16 subtract lanes sharing operand b
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mode4_sub_row
    import mode4_norm_dispatch_pkg::*;
#(
    parameter int DATAWIDTH = c_DATAWIDTH
) (
    input  logic [DATAWIDTH-1:0] a0,
    input  logic [DATAWIDTH-1:0] a1,
    input  logic [DATAWIDTH-1:0] a2,
    input  logic [DATAWIDTH-1:0] a3,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] y0,
    output logic [DATAWIDTH-1:0] y1,
    output logic [DATAWIDTH-1:0] y2,
    output logic [DATAWIDTH-1:0] y3
);

    logic [DATAWIDTH-1:0] a_arr [4];
    logic [DATAWIDTH-1:0] y_arr [4];

    assign a_arr[0] = a0;
    assign a_arr[1] = a1;
    assign a_arr[2] = a2;
    assign a_arr[3] = a3;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign y_arr[k] = fp16_sub(a_arr[k], b);
        end
    endgenerate

    assign y0 = y_arr[0];
    assign y1 = y_arr[1];
    assign y2 = y_arr[2];
    assign y3 = y_arr[3];

endmodule

`default_nettype wire

// File: rtl/mode4_norm_dispatch.sv
// ============================================================================
// Module : mode4_norm_dispatch
// Brief  : Row dispatcher subtracting a latched norm from each 4-wide fp16 beat
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mode4_norm_dispatch
    import mode4_norm_dispatch_pkg::*;
#(
    parameter int DATAWIDTH = c_DATAWIDTH,
    parameter int LENWIDTH  = c_LENWIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [LENWIDTH-1:0]  len,
    input  logic [DATAWIDTH-1:0] norm_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] inp0,
    input  logic [DATAWIDTH-1:0] inp1,
    input  logic [DATAWIDTH-1:0] inp2,
    input  logic [DATAWIDTH-1:0] inp3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] outp0,
    output logic [DATAWIDTH-1:0] outp1,
    output logic [DATAWIDTH-1:0] outp2,
    output logic [DATAWIDTH-1:0] outp3,
    output logic                 busy,
    output logic                 done
);

    state_t               state_q, state_d;
    logic [LENWIDTH-1:0]  beats_left_q, beats_left_d;
    logic [DATAWIDTH-1:0] norm_q, norm_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic [DATAWIDTH-1:0] outp_q [4];
    logic [DATAWIDTH-1:0] outp_d [4];
    logic [DATAWIDTH-1:0] diff [4];
    logic                 accept, pop;

    mode4_sub_row #(
        .DATAWIDTH (DATAWIDTH)
    ) u_sub_row (
        .a0 (inp0),
        .a1 (inp1),
        .a2 (inp2),
        .a3 (inp3),
        .b  (norm_q),
        .y0 (diff[0]),
        .y1 (diff[1]),
        .y2 (diff[2]),
        .y3 (diff[3])
    );

    assign accept = in_valid && in_ready;
    assign pop    = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (start && (len != '0))                         state_d = c_ST_RUN;
            c_ST_RUN:   if (accept && (beats_left_q == LENWIDTH'(1)))     state_d = c_ST_DRAIN;
            c_ST_DRAIN: if (pop)                                          state_d = c_ST_IDLE;
            default:                                                      state_d = c_ST_IDLE;
        endcase
    end

    // One-entry output register: a pop in the same cycle frees the slot for a new beat.
    always_comb begin
        busy     = (state_q != c_ST_IDLE);
        in_ready = (state_q == c_ST_RUN) && (!out_valid_q || out_ready);
    end

    always_comb begin
        norm_d       = norm_q;
        beats_left_d = beats_left_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        outp_d       = outp_q;
        if ((state_q == c_ST_IDLE) && start) begin
            if (len != '0) begin
                norm_d       = norm_in;
                beats_left_d = len;
            end else begin
                done_d = 1'b1;
            end
        end
        if (accept) begin
            outp_d       = diff;
            out_valid_d  = 1'b1;
            beats_left_d = beats_left_q - LENWIDTH'(1);
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
        if ((state_q == c_ST_DRAIN) && pop) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            norm_q       <= '0;
            beats_left_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                outp_q[k] <= '0;
            end
        end else begin
            norm_q       <= norm_d;
            beats_left_q <= beats_left_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            outp_q       <= outp_d;
        end
    end

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign outp0     = outp_q[0];
    assign outp1     = outp_q[1];
    assign outp2     = outp_q[2];
    assign outp3     = outp_q[3];

endmodule

`default_nettype wire

// File: tb/tb_mode4_norm_dispatch.sv
// ============================================================================
// Module : tb_mode4_norm_dispatch
// Brief  : Directed bench with a real-arithmetic fp16 model and row scoreboard
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mode4_norm_dispatch;

    logic        clk = 1'b0;
    logic        reset_n, start, in_valid, out_ready;
    logic [7:0]  len;
    logic [15:0] norm_in, inp0, inp1, inp2, inp3;
    logic        in_ready, out_valid, busy, done;
    logic [15:0] outp0, outp1, outp2, outp3;

    always #5 clk = ~clk;

    mode4_norm_dispatch #(.DATAWIDTH(16), .LENWIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .norm_in(norm_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .inp0(inp0), .inp1(inp1), .inp2(inp2), .inp3(inp3),
        .out_valid(out_valid), .out_ready(out_ready),
        .outp0(outp0), .outp1(outp1), .outp2(outp2), .outp3(outp3),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- fp16 reference via exact real arithmetic ----------------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
        else                  v = real'(1024 + h[9:0]) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic int rne(input real m);
        int  f  = int'($floor(m));
        real fr = m - real'(f);
        if (fr > 0.5 || (fr == 0.5 && (f % 2) == 1)) f++;
        return f;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s = (x < 0.0);
        real  a = s ? -x : x;
        int   e = 0;
        int   n;
        while (a >= pow2(e + 1)) e++;
        while (a < pow2(e)) e--;
        if (e < -14) begin
            n = rne(a / pow2(-24));
            return {s, 15'(n)};
        end
        n = rne(a / pow2(e - 10));
        if (n == 2048) begin n = 1024; e++; end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] hsub(input logic [15:0] a, input logic [15:0] b);
        logic an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        logic bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        logic ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        logic bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        real  dv;
        if (an || bn) return 16'h7E00;
        if (ai && bi) return (a[15] == b[15]) ? 16'h7E00 : a;
        if (ai) return a;
        if (bi) return {~b[15], 15'h7C00};
        dv = h2r(a) - h2r(b);
        if (dv == 0.0) return {a[15] & ~b[15], 15'd0};
        return r2h(dv);
    endfunction

    // ---------------- row-level model and per-cycle compare -------------------
    bit          m_busy = 0, m_ov = 0, m_done = 0;
    int          m_left = 0;
    logic [15:0] m_norm = '0;
    logic [63:0] expq [$];
    int          cyc = 0, done_cnt = 0, pop_cnt = 0, ov_cnt = 0, busy_cnt = 0;
    int          ov_first = -1, ov_last = -1;
    logic [63:0] last_pop = '0;

    always @(negedge clk) begin
        bit exp_ir, acc, pp, nd;
        int pre_left;
        cyc++;
        if (!reset_n) begin
            m_busy = 0; m_ov = 0; m_done = 0; m_left = 0; m_norm = '0;
            expq.delete();
            check("reset_flags", {in_ready, out_valid, busy, done}, 64'd0);
            check("reset_outp", {outp3, outp2, outp1, outp0}, 64'd0);
        end else begin
            exp_ir = m_busy && (m_left > 0) && (!m_ov || out_ready);
            check("in_ready", in_ready, exp_ir);
            check("out_valid", out_valid, m_ov);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (m_ov && expq.size() > 0)
                check("outp", {outp3, outp2, outp1, outp0}, expq[0]);
            done_cnt += int'(done);
            ov_cnt   += int'(out_valid);
            busy_cnt += int'(busy);
            if (out_valid) begin
                if (ov_first < 0) ov_first = cyc;
                ov_last = cyc;
            end
            if (out_valid && out_ready) begin
                pop_cnt++;
                last_pop = {outp3, outp2, outp1, outp0};
            end
            acc      = in_valid && exp_ir;
            pp       = m_ov && out_ready;
            pre_left = m_left;
            nd       = 0;
            if (pp) begin
                void'(expq.pop_front());
                m_ov = 0;
            end
            if (acc) begin
                expq.push_back({hsub(inp3, m_norm), hsub(inp2, m_norm),
                                hsub(inp1, m_norm), hsub(inp0, m_norm)});
                m_ov = 1;
                m_left--;
            end
            if (!m_busy) begin
                if (start) begin
                    if (len != 0) begin
                        m_busy = 1; m_left = int'(len); m_norm = norm_in;
                    end else begin
                        nd = 1;
                    end
                end
            end else if (pre_left == 0 && pp) begin
                m_busy = 0;
                nd     = 1;
            end
            m_done = nd;
        end
    end

    // ---------------- stimulus helpers ----------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_row(input logic [15:0] nrm, input logic [7:0] l);
        start = 1; norm_in = nrm; len = l;
        tick(1);
        start = 0;
    endtask

    task automatic set_beat(input logic [15:0] a3, a2, a1, a0);
        inp3 = a3; inp2 = a2; inp1 = a1; inp0 = a0;
    endtask

    task automatic wait_done(input string name, input int d0);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done_cnt > d0) begin ok = 1; break; end
        end
        check({name, "_timeout"}, ok, 1'b1);
    endtask

    task automatic one_beat_row(input string name, input logic [15:0] nrm,
                                input logic [63:0] beat, input logic [63:0] want);
        int d0 = done_cnt, p0 = pop_cnt;
        out_ready = 1;
        start_row(nrm, 8'd1);
        set_beat(beat[63:48], beat[47:32], beat[31:16], beat[15:0]);
        in_valid = 1;
        tick(1);
        in_valid = 0;
        wait_done(name, d0);
        check({name, "_data"}, last_pop, want);
        check({name, "_pops"}, pop_cnt - p0, 1);
        check({name, "_dones"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0, p0, o0, b0;
        reset_n = 0; start = 0; len = '0; norm_in = '0; in_valid = 0; out_ready = 0;
        set_beat(16'h0, 16'h0, 16'h0, 16'h0);
        tick(2);
        check("rst_state", {in_ready, out_valid, busy, done, outp3, outp2, outp1, outp0}, 64'd0);
        reset_n = 1;
        tick(1);

        // Basic row and lane arithmetic
        one_beat_row("basic", 16'h3C00, {16'h4400, 16'h4200, 16'h4000, 16'h3C00},
                     {16'h4200, 16'h4000, 16'h3C00, 16'h0000});
        one_beat_row("subnorm", 16'h0001, {16'h3C00, 16'h8001, 16'h0001, 16'h0400},
                     {16'h3C00, 16'h8002, 16'h0000, 16'h03FF});
        one_beat_row("special", 16'h3C00, {16'hC000, 16'h3C01, 16'hFC00, 16'h7C00},
                     {16'hC200, 16'h1400, 16'hFC00, 16'h7C00});

        // Streaming at full rate
        d0 = done_cnt; p0 = pop_cnt; o0 = ov_cnt; ov_first = -1; ov_last = -1;
        out_ready = 1; in_valid = 1;
        start_row(16'h3C00, 8'd4);
        for (int i = 0; i < 6; i++) begin
            set_beat(16'h4400 + 16'(i), 16'h4200 + 16'(i), 16'h4000 + 16'(i), 16'h3C00 + 16'(i));
            tick(1);
        end
        in_valid = 0;
        wait_done("stream", d0);
        check("stream_ov_cycles", ov_cnt - o0, 4);
        check("stream_no_bubble", ov_last - ov_first + 1, 4);
        check("stream_dones", done_cnt - d0, 1);

        // Backpressure mid-row
        d0 = done_cnt; p0 = pop_cnt;
        in_valid = 1;
        set_beat(16'h4800, 16'h4600, 16'h4400, 16'h4200);
        start_row(16'h3C00, 8'd4);
        tick(2);
        out_ready = 0;
        tick(1);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        tick(2);
        out_ready = 1;
        tick(4);
        in_valid = 0;
        wait_done("bp", d0);
        check("bp_pops", pop_cnt - p0, 4);
        check("bp_dones", done_cnt - d0, 1);

        // Zero-length row
        d0 = done_cnt; o0 = ov_cnt; b0 = busy_cnt;
        start_row(16'h3C00, 8'd0);
        tick(3);
        check("zero_dones", done_cnt - d0, 1);
        check("zero_busy", busy_cnt - b0, 0);
        check("zero_ov", ov_cnt - o0, 0);

        // Start while busy is ignored
        d0 = done_cnt; p0 = pop_cnt;
        start_row(16'h3C00, 8'd2);
        set_beat(16'h4400, 16'h4200, 16'h4000, 16'h3C00);
        in_valid = 1; start = 1; norm_in = 16'h4000; len = 8'd5;
        tick(1);
        start = 0;
        tick(1);
        in_valid = 0;
        wait_done("busy_start", d0);
        check("busy_start_data", last_pop, {16'h4200, 16'h4000, 16'h3C00, 16'h0000});
        check("busy_start_pops", pop_cnt - p0, 2);

        // Reset in the middle of a row
        d0 = done_cnt;
        in_valid = 1;
        start_row(16'h3C00, 8'd4);
        tick(2);
        reset_n = 0;
        #1;
        check("midrst_outs", {in_ready, out_valid, busy, done, outp3, outp2, outp1, outp0}, 64'd0);
        in_valid = 0;
        tick(2);
        reset_n = 1;
        tick(3);
        check("midrst_no_done", done_cnt - d0, 0);
        one_beat_row("after_rst", 16'h3C00, {16'h4400, 16'h4200, 16'h4000, 16'h3C00},
                     {16'h4200, 16'h4000, 16'h3C00, 16'h0000});

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
